// File: rtl/i2c_axis_target_rx.sv
// I2C target write receiver: START/STOP detect, 7-bit address match, ACK by SDA pull-down, bytes out on AXI-Stream.
// Define I2C_RX_GLITCH_FILTER_EN to add a FILTER_LEN-sample counter filter on SCL/SDA after the synchronizers.
module i2c_axis_target_rx #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       i2c_scl,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_oe,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tuser,
    output logic       busy,
    output logic       overflow
);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
        $error("i2c_axis_target_rx: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_c, sda_c;
    logic scl_prev_q, sda_prev_q;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       first_q, first_d;
    logic       ack_q, ack_d;
    logic       slot_q, slot_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       tvalid_q, tvalid_d;
    logic [7:0] tdata_q, tdata_d;
    logic       tuser_q, tuser_d;
    logic       ovf_q, ovf_d;

    // Synchronizers preset high so reset looks like an idle bus
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_i};
        end
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

    logic              scl_filt_q, sda_filt_q;
    logic [FCNT_W-1:0] scl_cnt_q, sda_cnt_q;

    // A level change is accepted only after FILTER_LEN consecutive samples of the new level
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            if (scl_sync_q[SYNC_STAGES-1] != scl_filt_q) begin
                if (scl_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                    scl_filt_q <= scl_sync_q[SYNC_STAGES-1];
                    scl_cnt_q  <= '0;
                end else begin
                    scl_cnt_q <= scl_cnt_q + FCNT_W'(1);
                end
            end else begin
                scl_cnt_q <= '0;
            end
            if (sda_sync_q[SYNC_STAGES-1] != sda_filt_q) begin
                if (sda_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                    sda_filt_q <= sda_sync_q[SYNC_STAGES-1];
                    sda_cnt_q  <= '0;
                end else begin
                    sda_cnt_q <= sda_cnt_q + FCNT_W'(1);
                end
            end else begin
                sda_cnt_q <= '0;
            end
        end
    end

    assign scl_c = scl_filt_q;
    assign sda_c = sda_filt_q;
`else
    assign scl_c = scl_sync_q[SYNC_STAGES-1];
    assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

    logic start_c, stop_c, scl_rise_c, scl_fall_c, last_bit_c, addr_match_c;
    assign start_c      = scl_c & sda_prev_q & ~sda_c;
    assign stop_c       = scl_c & ~sda_prev_q & sda_c;
    assign scl_rise_c   = ~scl_prev_q & scl_c;
    assign scl_fall_c   = scl_prev_q & ~scl_c;
    assign last_bit_c   = (bit_cnt_q == 3'd7);
    assign addr_match_c = ({shift_q, sda_c} == {DEV_ADDR, 1'b0});

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // START/STOP outrank bit sampling in every state
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = S_ADDR;
        end else if (stop_c) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:     if (scl_rise_c && last_bit_c) state_d = addr_match_c ? S_ADDR_ACK : S_IGNORE;
                S_DATA:     if (scl_rise_c && last_bit_c) state_d = S_DATA_ACK;
                S_ADDR_ACK,
                S_DATA_ACK: if (scl_fall_c && slot_q) state_d = S_DATA;
                default:    ;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        first_d   = first_q;
        ack_d     = ack_q;
        slot_d    = slot_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        ovf_d     = 1'b0;
        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
        if (start_c) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            first_d   = 1'b1;
            slot_d    = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_c) begin
            bit_cnt_d = '0;
            slot_d    = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise_c) begin
                        shift_d   = {shift_q[5:0], sda_c};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_c) begin
                            slot_d = 1'b0;
                            ack_d  = addr_match_c;
                            if (state_q == S_DATA) begin
                                // Load only if the output register is free at this edge
                                if (!tvalid_q || m_axis_tready) begin
                                    tvalid_d = 1'b1;
                                    tdata_d  = {shift_q, sda_c};
                                    tuser_d  = first_q;
                                    first_d  = 1'b0;
                                    ack_d    = 1'b1;
                                end else begin
                                    ovf_d = 1'b1;
                                    ack_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall_c) begin
                        if (!slot_q) begin
                            slot_d = 1'b1;
                            oe_d   = ack_q;
                            if (state_q == S_ADDR_ACK) busy_d = 1'b1;
                        end else begin
                            slot_d    = 1'b0;
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            first_q    <= 1'b0;
            ack_q      <= 1'b0;
            slot_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tuser_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            first_q    <= first_d;
            ack_q      <= ack_d;
            slot_q     <= slot_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tuser_q    <= tuser_d;
            ovf_q      <= ovf_d;
        end
    end

    assign i2c_sda_oe    = oe_q;
    assign busy          = busy_q;
    assign overflow      = ovf_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_i2c_axis_target_rx.sv
// Self-checking bench for i2c_axis_target_rx: a bit-banged I2C master on an open-drain bus with randomized bytes.
module tb_i2c_axis_target_rx;

    localparam int unsigned Q = 12;

    logic       clk = 1'b0;
    logic       arstn = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       tready = 1'b0;
    logic       sda_bus;
    logic       sda_oe, tvalid, tuser, busy, overflow;
    logic [7:0] tdata;

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] cap_q[$];
    int ovf_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_axis_target_rx dut (
        .clk          (clk),
        .arstn        (arstn),
        .i2c_scl      (scl),
        .i2c_sda_i    (sda_bus),
        .i2c_sda_oe   (sda_oe),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tdata (tdata),
        .m_axis_tuser (tuser),
        .busy         (busy),
        .overflow     (overflow)
    );

    // Inputs change just after posedge, so a negedge sample sees what the next edge will act on
    always @(negedge clk) begin
        if (tvalid && tready) cap_q.push_back({tuser, tdata});
        if (overflow) ovf_cnt++;
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; tick(Q);
        scl = 1'b1; tick(2 * Q);
        scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        ack = ~sda_bus;
        tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        tick(3);
        tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_oe got %b want 0", sda_oe); end
        tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        tests_run++; if (tdata !== 8'h00) begin tests_failed++; $display("FAIL reset_tdata got %h want 00", tdata); end
        tests_run++; if (tuser !== 1'b0) begin tests_failed++; $display("FAIL reset_tuser got %b want 0", tuser); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
        arstn = 1'b1;
        tick(Q);
    endtask

    task automatic test_write();
        logic [7:0] data[$];
        logic [8:0] exp_q[$];
        logic       ack, first;
        int         base, ovf_base, n;
        for (int it = 0; it < 3; it++) begin
            data.delete();
            exp_q.delete();
            if (it == 0) begin
                data.push_back(8'h3C);
                data.push_back(8'hF1);
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) data.push_back(8'($urandom_range(0, 255)));
            end
            first = 1'b1;
            foreach (data[k]) begin
                exp_q.push_back({first, data[k]});
                first = 1'b0;
            end
            tready = 1'b1;
            base = cap_q.size();
            ovf_base = ovf_cnt;
            i2c_start();
            send_byte(8'hA0, ack);
            tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL write_addr_ack it%0d got %b want 1", it, ack); end
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL write_busy it%0d got %b want 1", it, busy); end
            foreach (data[k]) begin
                send_byte(data[k], ack);
                tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL write_data_ack it%0d byte%0d got %b want 1", it, k, ack); end
            end
            tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL write_busy_end it%0d got %b want 1", it, busy); end
            i2c_stop();
            tick(Q);
            tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL write_busy_stop it%0d got %b want 0", it, busy); end
            tests_run++; if (ovf_cnt - ovf_base !== 0) begin tests_failed++; $display("FAIL write_overflow it%0d got %0d want 0", it, ovf_cnt - ovf_base); end
            tests_run++;
            if (cap_q.size() - base !== exp_q.size()) begin
                tests_failed++; $display("FAIL write_count it%0d got %0d want %0d", it, cap_q.size() - base, exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && base + k < cap_q.size(); k++) begin
                tests_run++;
                if (cap_q[base + k] !== exp_q[k]) begin
                    tests_failed++; $display("FAIL write_xfer it%0d #%0d got %h want %h", it, k, cap_q[base + k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_mismatch();
        logic       ack;
        logic [6:0] a;
        logic [7:0] addr_b;
        int         base, oe_base, busy_base;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                addr_b = 8'hA2;
            end else begin
                do a = 7'($urandom_range(0, 127)); while (a == 7'h50);
                addr_b = {a, 1'b0};
            end
            tready = 1'b1;
            base = cap_q.size(); oe_base = oe_cnt; busy_base = busy_cnt;
            i2c_start();
            send_byte(addr_b, ack);
            tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL mismatch_ack addr %h got %b want 0", addr_b, ack); end
            send_byte((it == 0) ? 8'h55 : 8'($urandom_range(0, 255)), ack);
            i2c_stop();
            tick(Q);
            tests_run++; if (oe_cnt - oe_base !== 0) begin tests_failed++; $display("FAIL mismatch_oe addr %h got %0d want 0", addr_b, oe_cnt - oe_base); end
            tests_run++; if (cap_q.size() - base !== 0) begin tests_failed++; $display("FAIL mismatch_xfer addr %h got %0d want 0", addr_b, cap_q.size() - base); end
            tests_run++; if (busy_cnt - busy_base !== 0) begin tests_failed++; $display("FAIL mismatch_busy addr %h got %0d want 0", addr_b, busy_cnt - busy_base); end
        end
    endtask

    task automatic test_read();
        logic ack, ack2;
        int   base, oe_base;
        tready = 1'b1;
        base = cap_q.size(); oe_base = oe_cnt;
        i2c_start();
        send_byte(8'hA1, ack);
        send_byte(8'($urandom_range(0, 255)), ack2);
        i2c_stop();
        tick(Q);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL read_addr_ack got %b want 0", ack); end
        tests_run++; if (ack2 !== 1'b0) begin tests_failed++; $display("FAIL read_ignore_ack got %b want 0", ack2); end
        tests_run++; if (oe_cnt - oe_base !== 0) begin tests_failed++; $display("FAIL read_oe got %0d want 0", oe_cnt - oe_base); end
        tests_run++; if (cap_q.size() - base !== 0) begin tests_failed++; $display("FAIL read_xfer got %0d want 0", cap_q.size() - base); end
    endtask

    task automatic test_backpressure();
        logic [7:0] data[3];
        logic [2:0] exp_ack;
        logic       ack;
        int         base, ovf_base;
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        exp_ack = 3'b001;  // only the first byte finds the output register empty
        tready = 1'b0;
        base = cap_q.size(); ovf_base = ovf_cnt;
        i2c_start();
        send_byte(8'hA0, ack);
        for (int k = 0; k < 3; k++) begin
            send_byte(data[k], ack);
            tests_run++; if (ack !== exp_ack[k]) begin tests_failed++; $display("FAIL bp_ack byte%0d got %b want %b", k, ack, exp_ack[k]); end
        end
        i2c_stop();
        tick(Q);
        tests_run++; if (ovf_cnt - ovf_base !== 2) begin tests_failed++; $display("FAIL bp_overflow got %0d want 2", ovf_cnt - ovf_base); end
        tests_run++; if ({tvalid, tuser, tdata} !== {2'b11, data[0]}) begin tests_failed++; $display("FAIL bp_hold got %b %b %h want 1 1 %h", tvalid, tuser, tdata, data[0]); end
        tready = 1'b1;
        tick(5);
        tests_run++; if (cap_q.size() - base !== 1) begin tests_failed++; $display("FAIL bp_count got %0d want 1", cap_q.size() - base); end
        if (cap_q.size() > base) begin
            tests_run++; if (cap_q[base] !== {1'b1, data[0]}) begin tests_failed++; $display("FAIL bp_xfer got %h want %h", cap_q[base], {1'b1, data[0]}); end
        end
        tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL bp_tvalid_after got %b want 0", tvalid); end
    endtask

    task automatic test_repeated_start();
        logic [7:0] b1, b2;
        logic [3:0] part;
        logic       ack;
        int         base;
        b1 = (8'h77); b2 = 8'h88;
        for (int it = 0; it < 2; it++) begin
            if (it == 1) begin
                b1 = 8'($urandom_range(0, 255));
                b2 = 8'($urandom_range(0, 255));
            end
            part = 4'($urandom_range(0, 15));
            tready = 1'b1;
            base = cap_q.size();
            i2c_start();
            send_byte(8'hA0, ack);
            send_byte(b1, ack);
            i2c_start();
            send_byte(8'hA0, ack);
            tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL rs_addr_ack it%0d got %b want 1", it, ack); end
            send_byte(b2, ack);
            for (int i = 3; i >= 0; i--) send_bit(part[i]);
            i2c_stop();
            tick(Q);
            tests_run++; if (cap_q.size() - base !== 2) begin tests_failed++; $display("FAIL rs_count it%0d got %0d want 2", it, cap_q.size() - base); end
            if (cap_q.size() >= base + 2) begin
                tests_run++; if (cap_q[base] !== {1'b1, b1}) begin tests_failed++; $display("FAIL rs_first it%0d got %h want %h", it, cap_q[base], {1'b1, b1}); end
                tests_run++; if (cap_q[base + 1] !== {1'b1, b2}) begin tests_failed++; $display("FAIL rs_second it%0d got %h want %h", it, cap_q[base + 1], {1'b1, b2}); end
            end
            tests_run++; if ({sda_oe, busy} !== 2'b00) begin tests_failed++; $display("FAIL rs_release it%0d got oe=%b busy=%b want 0 0", it, sda_oe, busy); end
        end
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic [7:0] b;
        int         base;
        tready = 1'b0;
        i2c_start();
        send_byte(8'hA0, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'b0);
        tests_run++; if ({sda_oe, tvalid} !== 2'b11) begin tests_failed++; $display("FAIL rm_slot got oe=%b tvalid=%b want 1 1", sda_oe, tvalid); end
        arstn = 1'b0;
        #1;
        tests_run++; if ({sda_oe, tvalid} !== 2'b00) begin tests_failed++; $display("FAIL rm_async got oe=%b tvalid=%b want 0 0", sda_oe, tvalid); end
        tick(2);
        sda_m = 1'b1;
        scl = 1'b1;
        tick(Q);
        arstn = 1'b1;
        tick(Q);
        b = 8'($urandom_range(0, 255));
        if (b == 8'h00) b = 8'h42;
        tready = 1'b1;
        base = cap_q.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(b, ack);
        i2c_stop();
        tick(Q);
        tests_run++; if (cap_q.size() - base !== 1) begin tests_failed++; $display("FAIL rm_count got %0d want 1", cap_q.size() - base); end
        if (cap_q.size() > base) begin
            tests_run++; if (cap_q[base] !== {1'b1, b}) begin tests_failed++; $display("FAIL rm_xfer got %h want %h", cap_q[base], {1'b1, b}); end
        end
    endtask

`ifdef I2C_RX_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        logic ack;
        sda_m = 1'b1; scl = 1'b1; tick(Q);
        sda_m = 1'b0; tick(2);
        sda_m = 1'b1; tick(Q);
        scl = 1'b0; tick(Q);
        send_byte(8'hA0, ack);
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL glitch_2clk got ack=%b want 0", ack); end
        sda_m = 1'b1; tick(Q);
        scl = 1'b1; tick(Q);
        sda_m = 1'b0; tick(6);
        scl = 1'b0; tick(Q);
        send_byte(8'hA0, ack);
        tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL glitch_6clk got ack=%b want 1", ack); end
        i2c_stop();
        tick(Q);
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_backpressure();
        test_repeated_start();
        test_reset_mid();
`ifdef I2C_RX_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
